adder_share_ctrl: RTL



---
 rtl/adder_share_pkg.sv | 13 +
 rtl/adder_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/adder_share_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the shared-adder controller.
package adder_share_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// at or above the pointer, wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     winner_o,
  output logic               any_o
);

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
  always_comb begin
    logic [IDW:0] idx;
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, ptr_i} + (IDW+1)'(off);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!any_o && req_i[idx[IDW-1:0]]) begin
        any_o                 = 1'b1;
        grant_o[idx[IDW-1:0]] = 1'b1;
        winner_o              = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Sequences one shared combinational adder between NUM_REQ requesters:
// round-robin grant, registered operands, captured sum, tagged response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The requester holds req_valid/operands until its
// req_ready; the controller holds resp_* stable while resp_valid is high
// and resp_ready is low.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  WIDTH   = DEF_WIDTH,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH:0]           add_sum,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_carry,
  output logic [IDW-1:0]           resp_id,
  output logic                     busy,
  output logic [1:0]               dbg_state,
  output logic [IDW-1:0]           dbg_ptr
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic               resp_carry_q, resp_carry_d;
  logic [IDW-1:0]     resp_id_q, resp_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     winner;
  logic               any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // Next-state and datapath-load decisions; every register holds by default.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_carry_d = resp_carry_q;
    resp_id_d    = resp_id_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (any_req) begin
          add_a_d = req_a[int'(winner)*WIDTH +: WIDTH];
          add_b_d = req_b[int'(winner)*WIDTH +: WIDTH];
          id_d    = winner;
          ptr_d   = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        resp_data_d  = add_sum[WIDTH-1:0];
        resp_carry_d = add_sum[WIDTH];
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Return to IDLE only; the next grant waits for the IDLE cycle.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_carry_q <= resp_carry_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_carry = resp_carry_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_ptr    = ptr_q;

endmodule
